mult_hilo_ctrl: RTL
===================

// Module: mult_hilo_ctrl
// PURPOSE
//   Sequencing controller for the 64-bit iterative shift-add multiplier in the MIPS EX stage.
//   Accepts MULT/MULTU requests from the pipeline and runs one multiplier bit per clock.
//   Applies the sign fix-up, then commits the 128-bit product to the architectural HI/LO registers.
//   Stalls MFHI/MFLO reads while a product is in flight; supports pipeline flush (abort).
// PARAMETERS
//   WIDTH   64  operand width; product is 2*WIDTH; HI = product[2W-1:W], LO = product[W-1:0]
//   CNT_W   7   iteration counter width, = $clog2(WIDTH)+1
// PORTS
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous, active-high; clears all state
//   req_valid   in   1      multiply request from EX stage
//   req_ready   out  1      high only in IDLE; accept = req_valid & req_ready & ~flush
//   req_signed  in   1      1 = MULT (two's complement), 0 = MULTU
//   req_a       in   WIDTH  multiplicand (rs)
//   req_b       in   WIDTH  multiplier (rt)
//   flush       in   1      abort the in-flight op; HI/LO are not written
//   hilo_rd     in   1      MFHI/MFLO in EX this cycle
//   stall       out  1      = hilo_rd & (state != IDLE); combinational
//   busy        out  1      state != IDLE
//   done        out  1      one-cycle pulse in the cycle HI/LO are updated
//   hi          out  WIDTH  HI register
//   lo          out  WIDTH  LO register
// BEHAVIOUR
//   Reset: state=IDLE, hi=lo=0, busy=done=stall=0, req_ready=1, internal regs=0.
//   FSM: IDLE -> RUN -> FIXUP -> COMMIT -> IDLE.
//   IDLE: on accept, latch operand magnitudes.
//     Signed: |a|, |b|, neg = a[W-1]^b[W-1].
//     Unsigned: a, b, neg = 0.
//     Clear acc (2W bits); ctr = 0.
//     Magnitudes are W-bit unsigned; -2^63 -> 2^63 must be exact.
//   RUN (exactly WIDTH cycles): if mp[0], acc += mc; mc <<= 1 (2W bits); mp >>= 1; ctr++.
//     Exit when ctr == WIDTH-1 is processed.
//   FIXUP (1 cycle): if neg, acc = ~acc + 1 (full 2W-bit negate, not a sign-bit set).
//   COMMIT (1 cycle): {hi,lo} <= acc; done = 1.
//   Latency: accept at edge 0; done high in cycle WIDTH+2 (66 for W=64); req_ready high the next cycle.
//   No pipelining: one op in flight; req_ready = 0 in RUN/FIXUP/COMMIT.
//   flush in RUN or FIXUP: next state IDLE; hi/lo unchanged; no done.
//   flush in COMMIT: ignored; the commit completes.
//   flush in IDLE with req_valid: flush wins; no accept.
//   hilo_rd during COMMIT still stalls; the read proceeds the following cycle with new values.
//   Reset mid-op: immediate return to reset state, including hi/lo = 0.
//   Operand inputs are sampled only at accept; later changes are ignored.
//   All arithmetic is unsigned on 2W-bit vectors; no X/Z compares (=== not used).
// STRUCTURE
//   Shared package mips_pkg: WIDTH, FSM state localparams
//     (S_IDLE=2'd0, S_RUN=2'd1, S_FIXUP=2'd2, S_COMMIT=2'd3), MULT/MULTU funct codes.
//   Sub-module mult_shift_add_step: registered mc/mp/acc datapath.
//     Ports: load, step, negate, operands.
//     This file holds FSM, counter, handshake, stall and the HI/LO registers.
// TESTING
//   1. MULTU 3 x 5 -> done at cycle 66 after accept; hi=0, lo=0xF; req_ready=0 cycles 1..66.
//   2. MULT -1 x 1 -> hi=lo=0xFFFF_FFFF_FFFF_FFFF.
//      Same operands as MULTU -> hi=0, lo=0xFFFF_FFFF_FFFF_FFFF.
//   3. MULT 0x8000_0000_0000_0000 x same -> hi=0x4000_0000_0000_0000, lo=0.
//   4. MULTU 0xFFFF_FFFF_FFFF_FFFF x same -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=1.
//   5. Preload hi/lo via 7x6; start 9x9; flush at RUN cycle 10 -> no done; hi=0, lo=42;
//      req_ready=1 next cycle; next op accepted cleanly.
//   6. hilo_rd held high from accept -> stall=1 through COMMIT, 0 the cycle after;
//      new op, reset at cycle 30 -> hi=lo=0, busy=0 asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS EX-stage multiplier.
//   WIDTH        operand width (product is 2*WIDTH)
//   CNT_W        iteration counter width, $clog2(WIDTH)+1
//   state_t      sequencing FSM states of mult_hilo_ctrl
//   FUNCT_MULT*  R-type funct codes that launch a multiply
package mips_pkg;

    localparam int WIDTH = 64;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FIXUP  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// mult_hilo_ctrl_if: pipeline <-> multiplier controller signal bundle.
//   master: EX-stage side (issues requests, flush, HI/LO reads; sees status and HI/LO)
//   slave : multiplier controller side
//   req_valid/req_ready/req_signed/req_a/req_b  multiply request handshake
//   flush                                        abort the in-flight op
//   hilo_rd / stall                              MFHI/MFLO interlock
//   busy / done / hi / lo                        status and architectural HI/LO
interface mult_hilo_ctrl_if #(
    parameter int WIDTH = mips_pkg::WIDTH
);

    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             flush;
    logic             hilo_rd;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output req_valid, req_signed, req_a, req_b, flush, hilo_rd,
        input  req_ready, stall, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_signed, req_a, req_b, flush, hilo_rd,
        output req_ready, stall, busy, done, hi, lo
    );

endinterface

// File: rtl/mult_shift_add_step.sv
// mult_shift_add_step: registered shift-add datapath for one multiply.
//   clk, reset  clock, asynchronous active-high reset
//   load        capture operand magnitudes and product sign, clear accumulator
//   step        one multiplier bit: acc += mc if mp[0]; mc <<= 1; mp >>= 1
//   negate      two's-complement the full accumulator if the product is negative
//   op_signed   1 = MULT, 0 = MULTU (sampled on load)
//   a, b        multiplicand / multiplier (sampled on load)
//   acc         2*WIDTH-bit accumulator (final product after fix-up)
module mult_shift_add_step #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               negate,
    input  logic               op_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] mc_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mp_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Magnitudes stay WIDTH-bit unsigned: negating the most negative value
    // wraps to 2^(WIDTH-1), which is exactly its magnitude when read unsigned.
    assign mag_a = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign mag_b = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_q  <= '0;
            mp_q  <= '0;
            acc_q <= '0;
            neg_q <= 1'b0;
        end else if (load) begin
            mc_q  <= {{WIDTH{1'b0}}, mag_a};
            mp_q  <= mag_b;
            acc_q <= '0;
            neg_q <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            if (mp_q[0]) begin
                acc_q <= acc_q + mc_q;
            end
            mc_q <= mc_q << 1;
            mp_q <= mp_q >> 1;
        end else if (negate && neg_q) begin
            // Full-width negate; setting only the top bit would be wrong.
            acc_q <= ~acc_q + (2*WIDTH)'(1);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: sequencing controller for the iterative MULT/MULTU unit.
// Runs IDLE -> RUN (WIDTH cycles) -> FIXUP -> COMMIT -> IDLE, owns the HI/LO
// registers and stalls MFHI/MFLO while a product is in flight.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears all state including HI/LO
//   bus    mult_hilo_ctrl_if.slave: request handshake, flush, hilo_rd/stall,
//          busy, done (one-cycle pulse when HI/LO are written), hi, lo
module mult_hilo_ctrl #(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    mult_hilo_ctrl_if.slave  bus
);

    import mips_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   ctr_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [2*WIDTH-1:0] acc;
    logic               load;
    logic               step;
    logic               negate;
    logic               commit;

    mult_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .negate    (negate),
        .op_signed (bus.req_signed),
        .a         (bus.req_a),
        .b         (bus.req_b),
        .acc       (acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        negate  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Flush beats a simultaneous request.
                if (bus.req_valid && !bus.flush) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (ctr_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIXUP;
                    end
                end
            end
            S_FIXUP: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    negate  = 1'b1;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                // Past the point of no return: flush is ignored here.
                commit  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_q <= '0;
        end else if (load) begin
            ctr_q <= '0;
        end else if (step) begin
            ctr_q <= ctr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            {hi_q, lo_q} <= acc;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_COMMIT);
    assign bus.stall     = bus.hilo_rd & (state_q != S_IDLE);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule
